// File: rtl/seq_det_arbiter.sv
// -----------------------------------------------------------------------------
// seq_det_arbiter
//
// Purpose:
//   Shares one serial Mealy "1001" (overlapping) sequence detector between two
//   serial bit sources. A round-robin arbiter grants one requester at a time.
//   The granted source then streams a frame of FRAME_LEN bits through the
//   detector. Each completed frame reports its detection count with a
//   one-cycle done pulse.
//
// Parameters:
//   FRAME_LEN : bits streamed per granted frame (>= 4)
//   CNT_W     : match counter width, saturating at 2^CNT_W-1
//
// Ports:
//   clock      in   system clock, all state on rising edge
//   reset      in   synchronous, active-low reset
//   req[1:0]   in   per-source frame request, held until done or abort
//   bit_in0    in   serial data of source 0 (sampled while granted)
//   bit_in1    in   serial data of source 1 (sampled while granted)
//   grant[1:0] out  registered one-hot grant, 00 when idle
//   busy       out  high while a frame is streaming
//   det        out  Mealy detect pulse (combinational, 0 outside STREAM)
//   done       out  one-cycle pulse after a completed frame
//   done_id    out  source index of the finished frame (valid with done)
//   match_cnt  out  detections in the finished frame (held until next done)
//
// Build option:
//   SEQ_DET_EARLY_STOP_EN : when defined, the first detection in a frame ends
//                           the frame immediately (match_cnt = 1).
// -----------------------------------------------------------------------------
module seq_det_arbiter #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic             bit_in0,
    input  logic             bit_in1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             det,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int BC_W = $clog2(FRAME_LEN);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // Detector states: S1 = seen "1", S2 = seen "10", S3 = seen "100".
    typedef enum logic [1:0] {
        D_S0 = 2'd0,
        D_S1 = 2'd1,
        D_S2 = 2'd2,
        D_S3 = 2'd3
    } det_e;

    state_e            state_q,     state_d;
    det_e              dstate_q,    dstate_d;
    logic [BC_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              served_q,    served_d;
    logic              last_q,      last_d;
    logic [1:0]        grant_q,     grant_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              done_id_q,   done_id_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

    logic              cur_bit_s;
    logic              det_s;
    logic              winner_s;
    logic              end_frame_s;

    function automatic det_e det_next(input det_e s, input logic b);
        case (s)
            D_S0:    det_next = b ? D_S1 : D_S0;
            D_S1:    det_next = b ? D_S1 : D_S2;
            D_S2:    det_next = b ? D_S1 : D_S3;
            D_S3:    det_next = b ? D_S1 : D_S0;
            default: det_next = D_S0;
        endcase
    endfunction

    assign cur_bit_s = served_q ? bit_in1 : bit_in0;
    assign det_s     = (state_q == ST_STREAM) && (dstate_q == D_S3) && cur_bit_s;
    // Round robin: the source not served last wins if it asks, else the other.
    assign winner_s  = req[~last_q] ? ~last_q : last_q;

`ifdef SEQ_DET_EARLY_STOP_EN
    assign end_frame_s = (bit_cnt_q == LAST_BIT) || det_s;
`else
    assign end_frame_s = (bit_cnt_q == LAST_BIT);
`endif

    // Next-state and registered-output logic for arbiter, detector and counters.
    always_comb begin
        state_d     = state_q;
        dstate_d    = dstate_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = cnt_q;
        served_d    = served_q;
        last_d      = last_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    served_d  = winner_s;
                    grant_d   = winner_s ? 2'b10 : 2'b01;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    dstate_d  = D_S0;
                    cnt_d     = '0;
                    state_d   = ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (!req[served_q]) begin
                    // Abort: drop the frame silently but still rotate priority.
                    state_d  = ST_IDLE;
                    grant_d  = 2'b00;
                    busy_d   = 1'b0;
                    last_d   = served_q;
                    dstate_d = D_S0;
                end else begin
                    dstate_d  = det_next(dstate_q, cur_bit_s);
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    if (det_s && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (end_frame_s) begin
                        state_d = ST_REPORT;
                        grant_d = 2'b00;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_REPORT: begin
                done_d      = 1'b1;
                done_id_d   = served_q;
                match_cnt_d = cnt_q;
                last_d      = served_q;
                dstate_d    = D_S0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = 2'b00;
                busy_d   = 1'b0;
                dstate_d = D_S0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dstate_q    <= D_S0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            served_q    <= 1'b0;
            last_q      <= 1'b1;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dstate_q    <= dstate_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            served_q    <= served_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign det       = det_s;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seq_det_arbiter
//
// Self-checking bench for seq_det_arbiter. It runs directed scenarios
// (pattern frames, alternation, abort, mid-frame reset) followed by randomized
// traffic. Outputs are compared every cycle against a frame-level reference
// model. The model keeps each frame's received bits in a queue and spots
// "1001" by looking at the tail of that queue.
// -----------------------------------------------------------------------------
module tb_seq_det_arbiter;

    localparam int FL       = 16;
    localparam int CW       = 2;
    localparam int HITS_MAX = (1 << CW) - 1;
`ifdef SEQ_DET_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic [1:0]    req;
    logic          bit_in0;
    logic          bit_in1;
    logic [1:0]    grant;
    logic          busy;
    logic          det;
    logic          done;
    logic          done_id;
    logic [CW-1:0] match_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit       m_known  = 1'b0;
    bit       m_active = 1'b0;
    bit       m_rep    = 1'b0;
    bit       m_last   = 1'b1;
    int       m_src    = 0;
    int       m_hits   = 0;
    bit       hist[$];
    bit [1:0] e_grant   = 2'b00;
    bit       e_busy    = 1'b0;
    bit       e_done    = 1'b0;
    bit       e_done_id = 1'b0;
    int       e_match   = 0;

    seq_det_arbiter #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .bit_in0   (bit_in0),
        .bit_in1   (bit_in1),
        .grant     (grant),
        .busy      (busy),
        .det       (det),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected detect: the frame's last three bits are 1,0,0 and the current bit is 1.
    function automatic bit model_det(input bit b0, input bit b1);
        bit b;
        int n;
        if (!m_active) return 1'b0;
        b = (m_src == 1) ? b1 : b0;
        n = hist.size();
        if (n < 3) return 1'b0;
        return hist[n-3] && !hist[n-2] && !hist[n-1] && b;
    endfunction

    // Advance the reference model across one rising edge.
    task automatic model_edge(input bit [1:0] r, input bit b0, input bit b1, input bit rn);
        bit d;
        int other;
        if (!rn) begin
            m_known = 1'b1; m_active = 1'b0; m_rep = 1'b0; m_last = 1'b1;
            hist.delete(); m_hits = 0;
            e_grant = 2'b00; e_busy = 1'b0; e_done = 1'b0; e_done_id = 1'b0; e_match = 0;
            return;
        end
        e_done = 1'b0;
        if (m_rep) begin
            e_done = 1'b1; e_done_id = m_src[0]; e_match = m_hits;
            m_last = m_src[0]; m_rep = 1'b0;
        end else if (m_active) begin
            if (!r[m_src]) begin
                m_active = 1'b0; m_last = m_src[0]; e_grant = 2'b00; e_busy = 1'b0;
            end else begin
                d = model_det(b0, b1);
                hist.push_back((m_src == 1) ? b1 : b0);
                if (d && m_hits < HITS_MAX) m_hits++;
                if (hist.size() == FL || (EARLY && d)) begin
                    m_active = 1'b0; m_rep = 1'b1; e_grant = 2'b00; e_busy = 1'b0;
                end
            end
        end else if (r != 2'b00) begin
            other = m_last ? 0 : 1;
            m_src = r[other] ? other : int'(m_last);
            m_active = 1'b1; hist.delete(); m_hits = 0;
            e_grant = (m_src == 1) ? 2'b10 : 2'b01; e_busy = 1'b1;
        end
    endtask

    task automatic step(input bit [1:0] r, input bit b0, input bit b1, input bit rn);
        req = r; bit_in0 = b0; bit_in1 = b1; reset = rn;
        #1;
        if (m_known) check_eq("det", int'(det), int'(model_det(b0, b1)));
        model_edge(r, b0, b1, rn);
        @(posedge clock);
        #1;
        check_eq("grant", int'(grant), int'(e_grant));
        check_eq("busy", int'(busy), int'(e_busy));
        check_eq("done", int'(done), int'(e_done));
        check_eq("done_id", int'(done_id), int'(e_done_id));
        check_eq("match_cnt", int'(match_cnt), e_match);
    endtask

    // Overlapping 1001 pattern aligned to the frame position: 1001001001...
    function automatic bit pat_bit();
        return m_active && ((hist.size() % 3) == 0);
    endfunction

    initial begin : main
        bit [1:0] rq;
        bit [6:0] v;
        bit       b;
        int       mode;
        req = 2'b00; bit_in0 = 1'b0; bit_in1 = 1'b0; reset = 1'b0;

        // Reset state
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b1);

        // Source 0, pattern frame: five overlapping detections, count saturates
        for (int i = 0; i < FL + 4; i++) step(2'b01, pat_bit(), 1'b0, 1'b1);

        // Both requesting: strict alternation, random data
        for (int i = 0; i < 3 * (FL + 2) + 2; i++)
            step(2'b11, 1'($urandom), 1'($urandom), 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);

        // Source 1 aborts at stream cycle 4, then both request
        step(2'b10, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(2'b10, 1'b0, pat_bit(), 1'b1);
        step(2'b00, 1'b0, 1'b1, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < FL + 3; i++) step(2'b11, pat_bit(), pat_bit(), 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);

        // Reset at stream cycle 2 after "1,0"; next frame 0,0,0,1,0,0,1 must not false-detect
        step(2'b01, 1'b0, 1'b0, 1'b1);
        step(2'b01, 1'b1, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        v = 7'b1001000;
        for (int i = 0; i < FL + 4; i++) begin
            b = (m_active && hist.size() < 7) ? v[hist.size()] : 1'b0;
            step(2'b01, b, 1'b0, 1'b1);
        end

        // Randomized traffic: sticky requests, occasional drops and resets
        rq = 2'b00;
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 150) == 0) mode = int'($urandom_range(0, 2));
            for (int s = 0; s < 2; s++) begin
                if (rq[s]) rq[s] = ($urandom_range(0, 63) != 0);
                else       rq[s] = ($urandom_range(0, 3) == 0);
            end
            if (mode == 1) begin
                b = pat_bit();
                step(rq, b, b, ($urandom_range(0, 499) != 0));
            end else if (mode == 2) begin
                step(rq, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 499) != 0));
            end else begin
                step(rq, 1'($urandom), 1'($urandom), ($urandom_range(0, 499) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
